ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. It is the opposite direction of the keyboard receiver path.
- Sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset), using the host-request protocol.
- Drives the open-drain PS2_KBCLK/PS2_KBDAT lines through active-low-drive enables.
- Raises `rx_inhibit` so the keyboard receiver ignores line activity while a transmission is in progress.

---
 rtl/ps2_host_tx.sv | 166 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked-out
// frame driven by the device, ACK capture, idle wait and timeout abort.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_start,
  input  logic       i_ps2c_in,
  input  logic       i_ps2d_in,
  output logic       o_ps2c_drive_low,
  output logic       o_ps2d_drive_low,
  output logic       o_busy,
  output logic       o_rx_inhibit,
  output logic       o_done,
  output logic       o_ack_ok,
  output logic       o_error
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_WAIT_ACK, S_WAIT_IDLE, S_DONE, S_ERROR
  } state_t;

  state_t        r_state, r_next;
  logic [1:0]    r_c_sync, r_d_sync;
  logic          r_c_filt, r_fall;
  logic [FW-1:0] r_filt_cnt;
  logic [IW-1:0] r_inh_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [9:0]    r_shift;
  logic [3:0]    r_bit_cnt;
  logic          r_dat_low, r_ack;

  logic w_c_s, w_d_s, w_inh_last, w_active, w_timeout;

  assign w_c_s      = r_c_sync[1];
  assign w_d_s      = r_d_sync[1];
  assign w_inh_last = (r_inh_cnt == IW'(INHIBIT_CYCLES - 1));
  assign w_active   = (r_state == S_REQ) || (r_state == S_SEND) ||
                      (r_state == S_WAIT_ACK) || (r_state == S_WAIT_IDLE);
  assign w_timeout  = w_active && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_c_sync <= '1;
      r_d_sync <= '1;
    end else begin
      r_c_sync <= {r_c_sync[0], i_ps2c_in};
      r_d_sync <= {r_d_sync[0], i_ps2d_in};
    end
  end

  // Level changes only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_c_filt   <= 1'b1;
      r_filt_cnt <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (w_c_s == r_c_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_c_filt   <= w_c_s;
        r_filt_cnt <= '0;
        r_fall     <= ~w_c_s;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      S_IDLE:      if (i_tx_start) r_next = S_INHIBIT;
      S_INHIBIT:   if (w_inh_last) r_next = S_REQ;
      S_REQ:       if (w_timeout) r_next = S_ERROR;
                   else if (r_fall) r_next = S_SEND;
      S_SEND:      if (w_timeout) r_next = S_ERROR;
                   else if (r_fall && (r_bit_cnt == 4'd9)) r_next = S_WAIT_ACK;
      S_WAIT_ACK:  if (w_timeout) r_next = S_ERROR;
                   else if (r_fall) r_next = S_WAIT_IDLE;
      S_WAIT_IDLE: if (w_timeout) r_next = S_ERROR;
                   else if (r_c_filt && w_d_s) r_next = S_DONE;
      S_DONE:      r_next = S_IDLE;
      S_ERROR:     r_next = S_IDLE;
      default:     r_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_dat_low <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_inh_cnt <= '0;
          if (i_tx_start) begin
            r_shift <= {1'b1, ~^i_tx_data, i_tx_data};
            r_ack   <= 1'b0;
          end
        end
        S_INHIBIT: begin
          r_inh_cnt <= r_inh_cnt + 1'b1;
          r_to_cnt  <= '0;
        end
        S_REQ, S_SEND, S_WAIT_ACK, S_WAIT_IDLE: begin
          r_to_cnt <= r_to_cnt + 1'b1;
          if (r_fall && !w_timeout) begin
            if (r_state == S_WAIT_ACK) begin
              r_ack <= ~w_d_s;
            end else if (r_state != S_WAIT_IDLE) begin
              r_dat_low <= ~r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= (r_state == S_REQ) ? 4'd1 : r_bit_cnt + 4'd1;
            end
          end
        end
        default: r_dat_low <= 1'b0;
      endcase
    end
  end

  always_comb begin
    o_ps2c_drive_low = 1'b0;
    o_ps2d_drive_low = 1'b0;
    o_done           = 1'b0;
    o_ack_ok         = 1'b0;
    o_error          = 1'b0;
    o_busy           = (r_state != S_IDLE);
    o_rx_inhibit     = (r_state != S_IDLE);
    case (r_state)
      S_INHIBIT: begin
        o_ps2c_drive_low = 1'b1;
        o_ps2d_drive_low = w_inh_last;
      end
      S_REQ:   o_ps2d_drive_low = 1'b1;
      S_SEND:  o_ps2d_drive_low = r_dat_low;
      S_DONE: begin
        o_done   = 1'b1;
        o_ack_ok = r_ack;
      end
      S_ERROR: o_error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines
// and a queue of expected frames/ACK results.
module tb_ps2_host_tx;
  localparam int unsigned INH = 40;
  localparam int unsigned TMO = 3000;
  localparam int unsigned FLT = 8;
  localparam int unsigned H   = 50;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] tx_data;
  logic tx_start;
  logic dev_clk, dev_dat;
  logic ps2c_pad, ps2d_pad;
  logic c_dl, d_dl, busy, rx_inhibit, done, ack_ok, error;

  assign ps2c_pad = dev_clk & ~c_dl;
  assign ps2d_pad = dev_dat & ~d_dl;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(FLT)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_tx_data(tx_data),
    .i_tx_start(tx_start),
    .i_ps2c_in(ps2c_pad),
    .i_ps2d_in(ps2d_pad),
    .o_ps2c_drive_low(c_dl),
    .o_ps2d_drive_low(d_dl),
    .o_busy(busy),
    .o_rx_inhibit(rx_inhibit),
    .o_done(done),
    .o_ack_ok(ack_ok),
    .o_error(error)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int stray = 0;
  logic last_ack = 1'b0;
  logic [10:0] exp_q[$];

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      last_ack = ack_ok;
    end
    if (error) err_cnt++;
    if ((ack_ok && !done) || (rx_inhibit !== busy)) stray++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic dev_xfer(input bit ack, input int inj_k, input int gl_k, input int rst_k,
                          output logic [9:0] bits);
    int n = 0;
    bits = '0;
    while (!(c_dl == 1'b0 && d_dl == 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("request_seen", (n < 400) ? 1 : 0, 1);
    if (n >= 400) return;
    repeat (20) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == rst_k) begin
        repeat (8) @(negedge clk);
        chk("pre_reset_dlow", d_dl, 1);
        rst = 1'b1;
        #1;
        chk("reset_clk_release", c_dl, 0);
        chk("reset_dat_release", d_dl, 0);
        chk("reset_busy", busy, 0);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (k == inj_k) begin
        repeat (10) @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (H - 11) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      if (k <= 10) bits[k-1] = ps2d_pad;
      dev_clk = 1'b1;
      if (k == gl_k) begin
        repeat (20) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H - 23) @(negedge clk);
      end else if (k == 10 && ack) begin
        repeat (H / 2) @(negedge clk);
        dev_dat = 1'b0;
        repeat (H - H / 2) @(negedge clk);
      end else if (k == 11) begin
        repeat (5) @(negedge clk);
        dev_dat = 1'b1;
        repeat (H - 5) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, input bit measure,
                          input int inj_k, input int gl_k);
    logic [10:0] e;
    logic [9:0] bits;
    int d0, e0, n, nc, nd;
    logic lastd;
    exp_q.push_back({ack, 1'b1, odd_par(d), d});
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(d);
    if (measure) begin
      nc = 0; nd = 0; lastd = 1'b0;
      while (c_dl && nc < 1000) begin
        nc++;
        if (d_dl) nd++;
        lastd = d_dl;
        @(negedge clk);
      end
      chk("inhibit_len", nc, INH);
      chk("start_bit_last", lastd, 1);
      chk("start_bit_once", nd, 1);
    end
    dev_xfer(ack, inj_k, gl_k, 0, bits);
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);
    e = exp_q.pop_front();
    chk("frame_bits", bits, e[9:0]);
    chk("ack_ok", last_ack, e[10]);
    @(negedge clk);
    chk("busy_after", busy, 0);
    repeat (200) @(posedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("no_error", err_cnt - e0, 0);
  endtask

  initial begin
    logic [9:0] bits;
    int n, d0, e0;
    rst = 1'b1; dev_clk = 1'b1; dev_dat = 1'b1; tx_start = 1'b0; tx_data = '0;
    repeat (5) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_clk_drive", c_dl, 0);
    chk("rst_dat_drive", d_dl, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ack", ack_ok, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_xfer(8'hED, 1'b1, 1'b1, 0, 0);
    run_xfer(8'h01, 1'b1, 1'b0, 0, 0);
    run_xfer(8'h00, 1'b1, 1'b0, 0, 0);
    run_xfer(8'h3C, 1'b0, 1'b0, 0, 0);

    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hA5);
    n = 0;
    while (c_dl && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!error && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, TMO);
    @(negedge clk);
    chk("to_clk_release", c_dl, 0);
    chk("to_dat_release", d_dl, 0);
    chk("to_busy", busy, 0);
    chk("to_err_pulses", err_cnt - e0, 1);
    chk("to_no_done", done_cnt - d0, 0);
    repeat (20) @(negedge clk);

    run_xfer(8'hED, 1'b1, 1'b0, 4, 5);

    d0 = done_cnt;
    start_tx(8'hED);
    dev_xfer(1'b1, 0, 0, 6, bits);
    repeat (300) @(posedge clk);
    chk("reset_no_done", done_cnt - d0, 0);
    run_xfer(8'hFF, 1'b1, 1'b0, 0, 0);

    chk("ack_err_held_low", stray, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
